// File: rtl/bcd_result_display_pkg.sv
// Shared glyphs, digit enables, FSM states and result record for bcd_result_display.
package bcd_result_display_pkg;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low one-hot digit enables; digit 3 is the sign position
    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;
    localparam logic [3:0] AN_NONE = 4'b1111;

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_SHOW  = 2'd1,
        ST_ERR   = 2'd2
    } state_e;

    // sign: 1 = non-negative, 0 = negative
    typedef struct packed {
        logic       sign;
        logic [3:0] huns;
        logic [3:0] tens;
        logic [3:0] ones;
    } result_t;

    // True when any digit of the result is not a legal BCD digit
    function automatic logic result_bad(result_t r);
        return (r.huns > 4'd9) || (r.tens > 4'd9) || (r.ones > 4'd9);
    endfunction

endpackage

// File: rtl/bcd_result_display_if.sv
// Valid/ready result channel from the BCD subtractor into the display stage.
interface bcd_result_display_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_ones;
    logic [3:0] in_tens;
    logic [3:0] in_huns;
    logic       in_sign;

    modport master (
        output in_valid,
        output in_ones,
        output in_tens,
        output in_huns,
        output in_sign,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_ones,
        input  in_tens,
        input  in_huns,
        input  in_sign,
        output in_ready
    );
endinterface

// File: rtl/bcd_result_display_bcd_to_seg.sv
// Combinational BCD digit to active-low seven-segment glyph; non-BCD codes show "E".
module bcd_to_seg
    import bcd_result_display_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    // Glyph lookup with blank override
    always_comb begin
        seg = SEG_E;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_E;
            endcase
        end
    end

endmodule

// File: rtl/bcd_result_display.sv
// Double-buffered signed 3-digit BCD result display on a 4-digit multiplexed
// seven-segment panel. Optional macro LZ_BLANK_EN blanks leading zeros in SHOW.
module bcd_result_display
    import bcd_result_display_pkg::*;
#(
    parameter int unsigned CLK_DIV = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_result_display_if.slave  in_bus,
    output logic [6:0]           seg,
    output logic [3:0]           an,
    output logic                 frame_done
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    state_e        state_q, state_d;
    result_t       pend_q, pend_d;
    result_t       active_q, active_d;
    logic          pend_full_q, pend_full_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          frame_done_q, frame_done_d;

    logic          tick;
    logic          xfer;
    logic          commit;
    logic [3:0]    mux_digit;
    logic          lz_blank;
    logic [6:0]    dig_seg;

    assign tick   = (presc_q == PRESC_MAX);
    assign xfer   = in_bus.in_valid && !pend_full_q;
    // Commit only at the 0->3 wrap so a scan frame never mixes two results
    assign commit = tick && (idx_q == 2'd0) && pend_full_q;

    assign in_bus.in_ready = !pend_full_q;
    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

    // State register and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= 2'd3;
            state_q      <= ST_BLANK;
            pend_q       <= '0;
            active_q     <= '0;
            pend_full_q  <= 1'b0;
            seg_q        <= SEG_BLANK;
            an_q         <= AN_NONE;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            pend_q       <= pend_d;
            active_q     <= active_d;
            pend_full_q  <= pend_full_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Prescaler, scan index, buffering and FSM next state
    always_comb begin
        presc_d     = tick ? '0 : presc_q + 1'b1;
        // 0 - 1 wraps to 3, giving the 3->2->1->0->3 order
        idx_d       = tick ? idx_q - 2'd1 : idx_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        active_d    = active_q;
        state_d     = state_q;

        if (xfer) begin
            pend_d.sign = in_bus.in_sign;
            pend_d.huns = in_bus.in_huns;
            pend_d.tens = in_bus.in_tens;
            pend_d.ones = in_bus.in_ones;
            pend_full_d = 1'b1;
        end

        if (commit) begin
            active_d    = pend_q;
            pend_full_d = 1'b0;
            unique case (state_q)
                ST_BLANK: state_d = ST_SHOW;
                ST_SHOW:  state_d = result_bad(pend_q) ? ST_ERR : ST_SHOW;
                ST_ERR:   state_d = result_bad(pend_q) ? ST_ERR : ST_SHOW;
                default:  state_d = ST_BLANK;
            endcase
        end
    end

    // Select the digit for the slot about to be lit, with optional leading-zero blanking
    always_comb begin
        mux_digit = active_d.ones;
        lz_blank  = 1'b0;
        case (idx_d)
            2'd2:    mux_digit = active_d.huns;
            2'd1:    mux_digit = active_d.tens;
            default: mux_digit = active_d.ones;
        endcase
`ifdef LZ_BLANK_EN
        lz_blank = ((idx_d == 2'd2) && (active_d.huns == 4'd0)) ||
                   ((idx_d == 2'd1) && (active_d.huns == 4'd0) && (active_d.tens == 4'd0));
`else
        lz_blank = 1'b0;
`endif
    end

    bcd_to_seg u_bcd_to_seg (
        .bcd   (mux_digit),
        .blank (lz_blank),
        .seg   (dig_seg)
    );

    // Load seg/an for the new slot on each tick, using post-commit contents
    always_comb begin
        seg_d        = seg_q;
        an_d         = an_q;
        frame_done_d = tick && (idx_d == 2'd0);

        if (tick) begin
            unique case (idx_d)
                2'd3:    an_d = AN_DIG3;
                2'd2:    an_d = AN_DIG2;
                2'd1:    an_d = AN_DIG1;
                default: an_d = AN_DIG0;
            endcase

            unique case (state_d)
                ST_SHOW: begin
                    if (idx_d == 2'd3) begin
                        seg_d = active_d.sign ? SEG_BLANK : SEG_MINUS;
                    end else begin
                        seg_d = dig_seg;
                    end
                end
                ST_ERR: begin
                    seg_d = (idx_d == 2'd3) ? SEG_E : SEG_BLANK;
                end
                default: begin
                    seg_d = SEG_BLANK;
                    an_d  = AN_NONE;
                end
            endcase
        end
    end

endmodule
